// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Summary  : Decode/issue stage feeding the ALU. It decodes the MIPS opcode
//            and funct fields into a 4-bit ALU control code and selects both
//            operands. Results are held in a registered valid/ready stage.
//            After a multiply (SMUL) fires, further issue is throttled for
//            MUL_LAT-1 cycles.
// Option   : define ALU_ISSUE_SKID_EN to add a one-entry skid buffer and a
//            registered in_ready_o.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT      = 3,
  parameter logic [3:0]  ILLEGAL_CODE = 4'hF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [5:0]  op_i,
  input  logic [5:0]  funct_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [3:0]  ctrl_o,
  output logic [31:0] src1_o,
  output logic [31:0] src2_o,
  output logic        illegal_o
);

  localparam logic [3:0] c_AND  = 4'd0,  c_OR   = 4'd1,  c_LW   = 4'd2,  c_SW   = 4'd3;
  localparam logic [3:0] c_ADDU = 4'd4,  c_SUBU = 4'd5,  c_SLT  = 4'd6,  c_BLEZ = 4'd7;
  localparam logic [3:0] c_SRA  = 4'd8,  c_SRAV = 4'd9,  c_LUI  = 4'd10, c_SLTU = 4'd11;
  localparam logic [3:0] c_SLL  = 4'd12, c_SMUL = 4'd13, c_BGTZ = 4'd14;
  localparam logic [3:0] c_HOLD_INIT = 4'(MUL_LAT - 1);
  localparam logic       c_THROTTLE  = (MUL_LAT > 1);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_FULL     = 2'd1,
    S_MUL_HOLD = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        valid_q;
  logic        ill_q;
  logic [3:0]  ctrl_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;

  logic [3:0]  w_dec_ctrl;
  logic        w_dec_ill;
  logic        w_dec_shift;
  logic        w_dec_imm;
  logic        w_dec_zext;
  logic [31:0] w_dec_src1;
  logic [31:0] w_dec_src2;

  // Decode opcode/funct into the ALU control code and operand selection
  always_comb begin
    w_dec_ctrl  = ILLEGAL_CODE;
    w_dec_ill   = 1'b0;
    w_dec_shift = 1'b0;
    w_dec_imm   = 1'b0;
    w_dec_zext  = 1'b0;
    if (op_i == 6'h00) begin
      case (funct_i)
        6'h21:   w_dec_ctrl = c_ADDU;
        6'h23:   w_dec_ctrl = c_SUBU;
        6'h24:   w_dec_ctrl = c_AND;
        6'h25:   w_dec_ctrl = c_OR;
        6'h2A:   w_dec_ctrl = c_SLT;
        6'h2B:   w_dec_ctrl = c_SLTU;
        6'h00:   begin w_dec_ctrl = c_SLL; w_dec_shift = 1'b1; end
        6'h03:   begin w_dec_ctrl = c_SRA; w_dec_shift = 1'b1; end
        6'h07:   w_dec_ctrl = c_SRAV;
        6'h18:   w_dec_ctrl = c_SMUL;
        default: w_dec_ill  = 1'b1;
      endcase
    end else begin
      w_dec_imm = 1'b1;
      case (op_i)
        6'h23:   w_dec_ctrl = c_LW;
        6'h2B:   w_dec_ctrl = c_SW;
        6'h0F:   begin w_dec_ctrl = c_LUI; w_dec_zext = 1'b1; end
        6'h06:   w_dec_ctrl = c_BLEZ;
        6'h07:   w_dec_ctrl = c_BGTZ;
        6'h09:   w_dec_ctrl = c_ADDU;
        6'h0A:   w_dec_ctrl = c_SLT;
        6'h0B:   w_dec_ctrl = c_SLTU;
        default: w_dec_ill  = 1'b1;
      endcase
    end
    // Shift amount sits in bits [10:6] of src1 so the ALU sees it unshifted-by-caller
    w_dec_src1 = w_dec_shift ? {21'b0, shamt_i, 6'b0} : rs_data_i;
    if (w_dec_imm)
      w_dec_src2 = w_dec_zext ? {16'b0, imm_i} : {{16{imm_i[15]}}, imm_i};
    else
      w_dec_src2 = rt_data_i;
  end

  logic w_held_smul;
  logic w_fire;
  logic w_accept;

  assign w_held_smul = valid_q & (ctrl_q == c_SMUL) & ~ill_q & c_THROTTLE;
  assign w_fire      = valid_q & out_ready_i;
  assign w_accept    = in_valid_i & in_ready_o;

  assign out_valid_o = valid_q;
  assign ctrl_o      = ctrl_q;
  assign src1_o      = src1_q;
  assign src2_o      = src2_q;
  assign illegal_o   = ill_q;

`ifdef ALU_ISSUE_SKID_EN
  logic        sk_valid_q;
  logic        sk_ill_q;
  logic [3:0]  sk_ctrl_q;
  logic [31:0] sk_src1_q;
  logic [31:0] sk_src2_q;
  logic        in_ready_q;
  logic        w_to_skid;
  logic        w_sk_valid_nxt;
  logic        w_out_smul_nxt;
  logic        w_hold_nxt;
  logic        w_ready_nxt;

  assign in_ready_o = in_ready_q & ~flush_i;

  // Predict next-cycle occupancy so in_ready_o can be registered
  always_comb begin
    w_to_skid      = (state_q == S_FULL) & ~w_fire;
    w_sk_valid_nxt = sk_valid_q ? ~w_fire : (w_accept & w_to_skid);
    if (w_fire & sk_valid_q)
      w_out_smul_nxt = (sk_ctrl_q == c_SMUL) & ~sk_ill_q & c_THROTTLE;
    else if (w_accept & ~w_to_skid)
      w_out_smul_nxt = (w_dec_ctrl == c_SMUL) & ~w_dec_ill & c_THROTTLE;
    else if (w_fire)
      w_out_smul_nxt = 1'b0;
    else
      w_out_smul_nxt = w_held_smul;
    w_hold_nxt  = ((state_q == S_FULL) & w_fire & ~sk_valid_q & ~w_accept & w_held_smul) |
                  ((state_q == S_MUL_HOLD) & (cnt_q != 4'd1));
    w_ready_nxt = ~w_sk_valid_nxt & ~w_hold_nxt & ~w_out_smul_nxt;
  end
`else
  // Ready while empty, or while full if the held op leaves this cycle and is not a throttled multiply
  always_comb begin
    in_ready_o = 1'b0;
    if (!flush_i) begin
      case (state_q)
        S_EMPTY: in_ready_o = 1'b1;
        S_FULL:  in_ready_o = out_ready_i & ~w_held_smul;
        default: in_ready_o = 1'b0;
      endcase
    end
  end
`endif

  // Issue FSM: output register, multiply throttle counter and optional skid entry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      ctrl_q  <= 4'd0;
      src1_q  <= 32'd0;
      src2_q  <= 32'd0;
      ill_q   <= 1'b0;
`ifdef ALU_ISSUE_SKID_EN
      sk_valid_q <= 1'b0;
      sk_ill_q   <= 1'b0;
      sk_ctrl_q  <= 4'd0;
      sk_src1_q  <= 32'd0;
      sk_src2_q  <= 32'd0;
      in_ready_q <= 1'b1;
`endif
    end else if (flush_i) begin
      // Only validity is dropped; data registers keep their contents
      state_q <= S_EMPTY;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
`ifdef ALU_ISSUE_SKID_EN
      sk_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
`endif
    end else begin
`ifdef ALU_ISSUE_SKID_EN
      in_ready_q <= w_ready_nxt;
      if (w_accept && w_to_skid) begin
        sk_valid_q <= 1'b1;
        sk_ctrl_q  <= w_dec_ctrl;
        sk_src1_q  <= w_dec_src1;
        sk_src2_q  <= w_dec_src2;
        sk_ill_q   <= w_dec_ill;
      end
`endif
      case (state_q)
        S_EMPTY: begin
          if (w_accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= w_dec_ctrl;
            src1_q  <= w_dec_src1;
            src2_q  <= w_dec_src2;
            ill_q   <= w_dec_ill;
            state_q <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_fire) begin
`ifdef ALU_ISSUE_SKID_EN
            if (sk_valid_q) begin
              sk_valid_q <= 1'b0;
              ctrl_q     <= sk_ctrl_q;
              src1_q     <= sk_src1_q;
              src2_q     <= sk_src2_q;
              ill_q      <= sk_ill_q;
            end else
`endif
            if (w_accept) begin
              ctrl_q <= w_dec_ctrl;
              src1_q <= w_dec_src1;
              src2_q <= w_dec_src2;
              ill_q  <= w_dec_ill;
            end else begin
              valid_q <= 1'b0;
              if (w_held_smul) begin
                state_q <= S_MUL_HOLD;
                cnt_q   <= c_HOLD_INIT;
              end else begin
                state_q <= S_EMPTY;
              end
            end
          end
        end
        S_MUL_HOLD: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_EMPTY;
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Summary  : Self-checking bench for alu_issue_ctrl: decode table vectors,
//            multiply throttle sequence, backpressure and flush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, in_valid_i, out_ready_i;
  logic        in_ready_o, out_valid_o, illegal_o;
  logic [5:0]  op_i, funct_i;
  logic [4:0]  shamt_i;
  logic [15:0] imm_i;
  logic [31:0] rs_data_i, rt_data_i, src1_o, src2_o;
  logic [3:0]  ctrl_o;

  int n_pass = 0;
  int n_total = 0;

  alu_issue_ctrl #(.MUL_LAT(3), .ILLEGAL_CODE(4'hF)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .funct_i(funct_i), .shamt_i(shamt_i), .imm_i(imm_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ctrl_o(ctrl_o), .src1_o(src1_o), .src2_o(src2_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        ill;
    logic        chk_src;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive_op(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                          input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
    op_i = op; funct_i = fn; shamt_i = sh; imm_i = imm; rs_data_i = rs; rt_data_i = rt;
  endtask

  initial begin
    //            op     funct  sh    imm       rs            rt            ctrl   s1            s2            ill  chk_src
    vecs[0]  = '{6'h00, 6'h21, 5'd0, 16'h0000, 32'd5,        32'd7,        4'd4,  32'd5,        32'd7,        1'b0, 1'b1};
    vecs[1]  = '{6'h00, 6'h23, 5'd0, 16'h0000, 32'd10,       32'd3,        4'd5,  32'd10,       32'd3,        1'b0, 1'b1};
    vecs[2]  = '{6'h00, 6'h24, 5'd0, 16'h0000, 32'hF0F0,     32'h0FF0,     4'd0,  32'hF0F0,     32'h0FF0,     1'b0, 1'b1};
    vecs[3]  = '{6'h00, 6'h25, 5'd0, 16'h0000, 32'h1,        32'h2,        4'd1,  32'h1,        32'h2,        1'b0, 1'b1};
    vecs[4]  = '{6'h00, 6'h2A, 5'd0, 16'h0000, 32'hFFFFFFFF, 32'd1,        4'd6,  32'hFFFFFFFF, 32'd1,        1'b0, 1'b1};
    vecs[5]  = '{6'h00, 6'h2B, 5'd0, 16'h0000, 32'd4,        32'd9,        4'd11, 32'd4,        32'd9,        1'b0, 1'b1};
    vecs[6]  = '{6'h00, 6'h00, 5'd3, 16'h0000, 32'hDEAD,     32'd1,        4'd12, 32'h000000C0, 32'd1,        1'b0, 1'b1};
    vecs[7]  = '{6'h00, 6'h03, 5'd4, 16'h0000, 32'h1234,     32'h80000000, 4'd8,  32'h00000100, 32'h80000000, 1'b0, 1'b1};
    vecs[8]  = '{6'h00, 6'h07, 5'd9, 16'h0000, 32'd2,        32'h40,       4'd9,  32'd2,        32'h40,       1'b0, 1'b1};
    vecs[9]  = '{6'h09, 6'h00, 5'd0, 16'hFFFE, 32'd3,        32'd0,        4'd4,  32'd3,        32'hFFFFFFFE, 1'b0, 1'b1};
    vecs[10] = '{6'h0F, 6'h00, 5'd0, 16'h1234, 32'h55,       32'd0,        4'd10, 32'h55,       32'h00001234, 1'b0, 1'b1};
    vecs[11] = '{6'h23, 6'h00, 5'd0, 16'h0010, 32'h1000,     32'd0,        4'd2,  32'h1000,     32'h00000010, 1'b0, 1'b1};
    vecs[12] = '{6'h2B, 6'h00, 5'd0, 16'h8000, 32'd4,        32'd0,        4'd3,  32'd4,        32'hFFFF8000, 1'b0, 1'b1};
    vecs[13] = '{6'h06, 6'h00, 5'd0, 16'hFFFF, 32'd9,        32'd0,        4'd7,  32'd9,        32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[14] = '{6'h07, 6'h00, 5'd0, 16'h0004, 32'd8,        32'd0,        4'd14, 32'd8,        32'h00000004, 1'b0, 1'b1};
    vecs[15] = '{6'h0B, 6'h00, 5'd0, 16'hFFFF, 32'd6,        32'd0,        4'd11, 32'd6,        32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[16] = '{6'h3F, 6'h00, 5'd0, 16'h0000, 32'd1,        32'd1,        4'hF,  32'd0,        32'd0,        1'b1, 1'b0};
    vecs[17] = '{6'h00, 6'h20, 5'd0, 16'h0000, 32'd1,        32'd1,        4'hF,  32'd0,        32'd0,        1'b1, 1'b0};

    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    drive_op(6'h00, 6'h00, 5'd0, 16'h0, 32'd0, 32'd0);

    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_ctrl",      32'(ctrl_o),      32'd0);
    chk("rst_src1",      src1_o,           32'd0);
    chk("rst_src2",      src2_o,           32'd0);
    chk("rst_illegal",   32'(illegal_o),   32'd0);
    chk("rst_in_ready",  32'(in_ready_o),  32'd1);

    // Decode table, back-to-back with the ALU always ready
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive_op(vecs[i].op, vecs[i].funct, vecs[i].shamt, vecs[i].imm, vecs[i].rs, vecs[i].rt);
      in_valid_i = 1'b1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready_o), 32'd1);
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(out_valid_o), 32'd1);
      chk($sformatf("v%0d_ctrl", i),  32'(ctrl_o),      32'(vecs[i].ctrl));
      chk($sformatf("v%0d_ill", i),   32'(illegal_o),   32'(vecs[i].ill));
      if (vecs[i].chk_src) begin
        chk($sformatf("v%0d_src1", i), src1_o, vecs[i].s1);
        chk($sformatf("v%0d_src2", i), src2_o, vecs[i].s2);
      end
    end

    // Drain the last op
    @(posedge clk);
    #1 chk("drain_valid", 32'(out_valid_o), 32'd0);

    // SMUL held under backpressure, then fired: issue blocked for 2 cycles
    @(negedge clk);
    drive_op(6'h00, 6'h18, 5'd0, 16'h0, 32'd6, 32'd7);
    in_valid_i = 1'b1; out_ready_i = 1'b0;
    @(posedge clk);
    #1;
    chk("smul_ctrl", 32'(ctrl_o), 32'd13);
    chk("smul_valid", 32'(out_valid_o), 32'd1);
    drive_op(6'h00, 6'h21, 5'd0, 16'h0, 32'd1, 32'd2);
    @(negedge clk);
    out_ready_i = 1'b1;
    chk("smul_full_ready", 32'(in_ready_o), 32'd0);
    @(posedge clk);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_in_ready", c), 32'(in_ready_o), 32'd0);
      chk($sformatf("hold%0d_valid", c),    32'(out_valid_o), 32'd0);
    end
    @(negedge clk);
    chk("hold_end_in_ready", 32'(in_ready_o), 32'd1);
    out_ready_i = 1'b0;
    @(posedge clk);
    #1;
    chk("post_smul_valid", 32'(out_valid_o), 32'd1);
    chk("post_smul_ctrl",  32'(ctrl_o),      32'd4);
    chk("post_smul_src1",  src1_o,           32'd1);
    chk("post_smul_src2",  src2_o,           32'd2);

    // Backpressure: held op stays put while a different op is offered
    drive_op(6'h00, 6'h23, 5'd0, 16'h0, 32'd99, 32'd98);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready_o), 32'd0);
      chk($sformatf("bp%0d_valid", c),    32'(out_valid_o), 32'd1);
      chk($sformatf("bp%0d_ctrl", c),     32'(ctrl_o),      32'd4);
      chk($sformatf("bp%0d_src1", c),     src1_o,           32'd1);
    end

    // Flush drops the held op; ready comes back the following cycle
    flush_i = 1'b1;
    #1 chk("flush_in_ready", 32'(in_ready_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    chk("flush_keeps_ctrl", 32'(ctrl_o), 32'd4);
    @(negedge clk);
    chk("after_flush_in_ready", 32'(in_ready_o), 32'd1);
    chk("after_flush_valid", 32'(out_valid_o), 32'd0);

    // Reset while full loses the op
    drive_op(6'h00, 6'h25, 5'd0, 16'h0, 32'd3, 32'd4);
    in_valid_i = 1'b1;
    @(posedge clk);
    #1 in_valid_i = 1'b0;
    chk("pre_rst_valid", 32'(out_valid_o), 32'd1);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_ctrl",  32'(ctrl_o),      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Decode/issue stage that drives the ALU from the other side of its control interface.
- Decodes MIPS opcode/funct into the team's 4-bit ALU control code and selects the ALU operands.
- Presents both through a registered valid/ready stage.
- After a multiply issues, throttles further issue for a fixed number of cycles. Sits between register-file read and the ALU in the multi-cycle CPU.

Parameters:
- MUL_LAT, 3, cycles the ALU needs for SMUL; range 1..15; 1 means no throttle.
- ILLEGAL_CODE, 4'hF, ctrl value issued for undecodable instructions.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard held op (branch/exception)
- in_valid_i  in  1  upstream op valid
- in_ready_o  out  1  block can accept
- op_i  in  6  instruction[31:26]
- funct_i  in  6  instruction[5:0]
- shamt_i  in  5  instruction[10:6]
- imm_i  in  16  instruction[15:0]
- rs_data_i  in  32  rs register value
- rt_data_i  in  32  rt register value
- out_valid_o  out  1  issued op valid
- out_ready_i  in  1  ALU consumes op
- ctrl_o  out  4  ALU control code
- src1_o  out  32  ALU operand 1
- src2_o  out  32  ALU operand 2
- illegal_o  out  1  held op is undecodable; qualified by out_valid_o

Behaviour:
- Clock and reset: one clock clk_i; rst_i is synchronous, active-high.
- Reset values: out_valid_o=0, ctrl_o=0, src1_o=0, src2_o=0, illegal_o=0, state=EMPTY, hold counter=0.
- Control codes: AND=0, OR=1, LW=2, SW=3, ADDU=4, SUBU=5, SLT=6, BLEZ=7, SRA=8, SRAV=9, LUI=10, SLTU=11, SLL=12, SMUL=13, BGTZ=14.
- Decode, op_i=0 (R-type), by funct:
  - 0x21→ADDU, 0x23→SUBU, 0x24→AND, 0x25→OR
  - 0x2A→SLT, 0x2B→SLTU, 0x00→SLL, 0x03→SRA
  - 0x07→SRAV, 0x18→SMUL
- Decode, non-R-type, by op:
  - 0x23→LW, 0x2B→SW, 0x0F→LUI
  - 0x06→BLEZ, 0x07→BGTZ
  - 0x09→ADDU, 0x0A→SLT, 0x0B→SLTU
- Illegal ops: any other op/funct issues ctrl=ILLEGAL_CODE with illegal_o=1.
- Operands:
  - SLL/SRA: src1={21'b0,shamt_i,6'b0}, src2=rt_data_i.
  - Other R-type (incl. SRAV): src1=rs_data_i, src2=rt_data_i.
  - LUI: src2={16'b0,imm_i}.
  - Other I-type: src2=sign-extended imm_i.
  - src1=rs_data_i for all except SLL/SRA.
  - BLEZ/BGTZ: src2=sign-extended imm_i (ALU compares src1 only).
- Handshakes:
  - Accept = in_valid_i & in_ready_o. Fire = out_valid_o & out_ready_i.
  - Output register loads on accept; latency 1 cycle.
  - Outputs hold stable while out_valid_o=1 and out_ready_i=0.
- State machine (in_ready_o combinational from state/out_ready_i):
  - EMPTY: in_ready_o=1. Accept → FULL.
  - FULL: in_ready_o=out_ready_i, except 0 when held ctrl=SMUL and MUL_LAT>1.
    - Fire & accept → reload, stay FULL.
    - Fire only, held op not SMUL or MUL_LAT=1 → EMPTY.
    - Fire of SMUL with MUL_LAT>1 → MUL_HOLD; counter=MUL_LAT-1.
  - MUL_HOLD: out_valid_o=0, in_ready_o=0. Counter decrements each cycle; at 1 → EMPTY on next edge. A SMUL fire therefore blocks issue for MUL_LAT-1 cycles.
- Flush and priority:
  - flush_i (priority below rst_i, above all else): out_valid_o=0, state=EMPTY, counter=0; in_ready_o=0 in flush cycle (no accept).
  - Data registers keep old values on flush; only valid clears.
  - Reset mid-MUL_HOLD or mid-FULL: same as reset, op lost.
- ctrl_o/src*_o/illegal_o change only on accept.

Optional Feature:
- Macro: ALU_ISSUE_SKID_EN.
- Defined:
  - Adds a one-entry skid buffer; in_ready_o becomes a registered signal, independent of out_ready_i.
  - An op accepted while FULL and not firing goes to the skid entry; in_ready_o drops next cycle.
  - On fire, the skid entry moves to the output register.
  - flush_i clears both entries.
  - The SMUL throttle applies to both entries: no accept while either holds SMUL with MUL_LAT>1.
- Undefined: single output register with combinational in_ready_o as above.

Test Plan:
- Reset: rst_i=1 for 2 cycles → out_valid_o=0, ctrl_o=0, src1_o=0, in_ready_o=1.
- ADDU: op=0, funct=0x21, rs=5, rt=7, out_ready=1 → next cycle ctrl_o=4, src1=5, src2=7, out_valid_o=1.
- ADDIU: op=0x09, imm=0xFFFE, rs=3 → ctrl_o=4, src2=0xFFFFFFFE. LUI: imm=0x1234 → ctrl_o=10, src2=0x00001234.
- SRA: funct=0x03, shamt=4, rt=0x80000000 → ctrl_o=8, src1=0x00000100. Undefined op 0x3F → ctrl_o=4'hF, illegal_o=1.
- SMUL, MUL_LAT=3: funct=0x18 issued, fired → in_ready_o=0 for exactly 2 cycles after fire, then 1; the following op is issued one cycle after acceptance.
- Backpressure then flush: out_ready=0 for 4 cycles → outputs stable, in_ready_o=0; flush_i=1 → out_valid_o=0 next cycle, in_ready_o=1 the cycle after.
